fft_sequencer: RTL and testbench
================================

# fft_sequencer

Top-level control sequencer for the 1024-point radix-2 FFT core. It loads a frame of samples into `fft_ram`, steps `address_generator` and `butterfly_unit` through all 10 stages × 512 butterflies, then streams the spectrum out in natural bin order by reading `fft_ram` at bit-reversed addresses. It drives only control and addresses; sample data flows directly between the stream ports and `fft_ram`.

## Interface
Parameters:
- `N_LOG2`, default 10: log2 of the FFT length. Only 10 is supported.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a frame. Sampled only in IDLE.
- `in_valid`  in  1  an input sample is present on the external data bus.
- `in_ready`  out  1  the sequencer accepts an input sample this cycle.
- `out_valid`  out  1  `fft_ram` A outputs hold bin `out_bin`.
- `out_ready`  in  1  the downstream side consumes the current bin.
- `out_bin`  out  10  natural-order bin index of the current output.
- `externalLoad`  out  1  write the external sample into `fft_ram` at `externalIndexA`.
- `scan`  out  1  `fft_ram` port A is addressed by `externalIndexA`, read-only.
- `externalIndexA`  out  10  external RAM address.
- `load`  out  1  write butterfly results into `fft_ram`.
- `stageCount`  out  5  current stage, 0–9.
- `cycleCount`  out  9  butterfly index within the stage, 0–511.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- `fft_ram` reads are asynchronous. Writes happen on the rising edge when `load` or `externalLoad` is high.
- FSM states: IDLE, LOAD, COMPUTE, UNLOAD. A single 10-bit counter `cnt` serves LOAD and UNLOAD.
- **IDLE**
  - All strobes are 0.
  - `start`=1 → LOAD, `cnt`←0.
- **LOAD**
  - `in_ready`=1.
  - `externalLoad` = `in_valid`.
  - `externalIndexA` = `cnt`, so input is written in natural order.
  - Each cycle with `in_valid`&`in_ready` increments `cnt`.
  - Acceptance at `cnt`=1023 → COMPUTE, with `stageCount`←0 and `cycleCount`←0.
- **COMPUTE**
  - `load`=1 every cycle.
  - `cycleCount` increments. At 511 it wraps to 0 and `stageCount` increments.
  - At `stageCount`=9 and `cycleCount`=511 → UNLOAD, `cnt`←0.
  - `cycleCount` and `stageCount` are 0 in every other state.
- **UNLOAD**
  - `scan`=1 and `out_valid`=1.
  - `out_bin` = `cnt`.
  - `externalIndexA` = bit-reverse(`cnt`), i.e. {cnt[0],…,cnt[9]}.
  - `out_valid`&`out_ready` increments `cnt`.
  - Acceptance at `cnt`=1023 → IDLE, with `done`=1 in the following cycle.
- Arithmetic:
  - Counters wrap modulo their width.
  - `externalIndexA` is 0 in IDLE and COMPUTE.
  - `out_bin` is 0 outside UNLOAD.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `start` held high through the `done` cycle begins a new frame in that cycle, since the FSM is already in IDLE.
  - `in_valid` gaps stall LOAD with no write.
  - `out_ready` low holds `out_bin`, `externalIndexA` and `out_valid` stable.
  - `in_valid` outside LOAD is ignored.
- Reset:
  - Any `rst` assertion, including mid-frame, immediately forces IDLE and clears all counters and outputs.
  - Partial frame data in RAM is abandoned.

## Timing
- Reset value of every output is 0.
- `start` high at edge t → LOAD from t, `in_ready`=1 in the cycle after t.
- With `in_valid` held high, LOAD lasts exactly 1024 cycles.
- COMPUTE lasts exactly 5120 cycles with `load`=1.
- `out_valid` first rises the cycle after the last COMPUTE cycle.
- With `out_ready` held high, UNLOAD lasts 1024 cycles.
- `done` pulses one cycle after the last output acceptance. `busy` is 0 in that same cycle.
- Minimum frame length, from the first `in_ready` to `done`: 7168 cycles.
- Outputs decode from registered state and counters. There is no combinational path from `in_valid` or `out_ready` to any output except `externalLoad`, which follows `in_valid`.

## Test plan
- **Reset:** assert `rst` for 3 cycles → all outputs 0, `busy`=0.
- **Impulse frame:** `start`, then sample 0 = (0x00010000, 0), other samples 0, `in_valid` and `out_ready` constant 1 → 1024 outputs, each real 0x00010000 ±1 LSB and imag 0 ±1 LSB. `out_bin` runs 0..1023. `done` arrives exactly 7168 cycles after the first `in_ready`.
- **Handshake stalls:** `in_valid` toggling 1,0,1,0 and `out_ready` low for 5 cycles at bin 37 → exactly 1024 writes at indices 0..1023. `out_bin` holds at 37 and `externalIndexA` holds at 0x290 during the stall. Spectrum matches the unstalled run.
- **COMPUTE counters:** sample the counters during COMPUTE → `(stageCount, cycleCount)` goes (0,0), (0,1)…(0,511), (1,0)…(9,511), 5120 cycles total with `load` always 1.
- **Start ignored:** pulse `start` during LOAD and during UNLOAD → no state or counter change.
- **Mid-frame reset:** assert `rst` at stage 4, cycle 100 → same cycle: `load`=0, `busy`=0, counters 0. A following `start` runs a clean full frame.

Source files
------------

// File: rtl/fft_sequencer.sv
// fft_sequencer: load / compute / unload control sequencer for the 1024-point radix-2 FFT core
module fft_sequencer #(
    parameter int N_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_LOG2-1:0] out_bin,
    output logic              externalLoad,
    output logic              scan,
    output logic [N_LOG2-1:0] externalIndexA,
    output logic              load,
    output logic [4:0]        stageCount,
    output logic [N_LOG2-2:0] cycleCount,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] UNLOAD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d, cnt_rev;
    logic [4:0]        stage_q, stage_d;
    logic [N_LOG2-2:0] cycle_q, cycle_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        cycle_d = cycle_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = COMPUTE;
                        stage_d = '0;
                        cycle_d = '0;
                    end
                end
            end
            COMPUTE: begin
                cycle_d = cycle_q + 1'b1;
                if (&cycle_q) begin
                    stage_d = stage_q + 1'b1;
                    if (stage_q == 5'(N_LOG2 - 1)) begin
                        state_d = UNLOAD;
                        stage_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            cycle_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < N_LOG2; i++) cnt_rev[i] = cnt_q[N_LOG2-1-i];
    end

    always_comb begin
        in_ready       = state_q == LOAD;
        externalLoad   = in_ready & in_valid;
        scan           = state_q == UNLOAD;
        out_valid      = scan;
        out_bin        = scan ? cnt_q : '0;
        externalIndexA = in_ready ? cnt_q : (scan ? cnt_rev : '0);
        load           = state_q == COMPUTE;
        stageCount     = load ? stage_q : '0;
        cycleCount     = load ? cycle_q : '0;
        busy           = state_q != IDLE;
        done           = done_q;
    end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized frames checked against a transaction-count model of the sequencer
module tb_fft_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, externalLoad, scan, load, busy, done;
    logic [9:0] out_bin, externalIndexA;
    logic [4:0] stageCount;
    logic [8:0] cycleCount;

    int checks = 0, failures = 0;
    bit m_act = 0, m_done = 0, seen_done = 0;
    int m_ld = 0, m_tk = 0, m_snt = 0;
    int tcyc = 0, first_ir = -1, done_at = -1, nwr = 0;

    fft_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .externalLoad(externalLoad), .scan(scan), .externalIndexA(externalIndexA),
        .load(load), .stageCount(stageCount), .cycleCount(cycleCount),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev10(input int v);
        int r = 0;
        for (int i = 0; i < 10; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // Phase is derived from how many samples were taken, compute cycles elapsed and bins sent.
    task automatic step();
        bit lp, cp, up;
        #1;
        lp = m_act && m_ld < 1024;
        cp = m_act && !lp && m_tk < 5120;
        up = m_act && !lp && !cp;
        check("strobes", {25'd0, in_ready, externalLoad, scan, out_valid, load, busy, done},
              {25'd0, lp, lp && in_valid, up, up, cp, m_act, m_done});
        check("index", 32'(externalIndexA), lp ? m_ld : (up ? rev10(m_snt) : 0));
        check("bin", 32'(out_bin), up ? m_snt : 0);
        check("stage", 32'(stageCount), cp ? m_tk / 512 : 0);
        check("cycle", 32'(cycleCount), cp ? m_tk % 512 : 0);
        if (in_ready && first_ir < 0) first_ir = tcyc;
        if (done) done_at = tcyc;
        if (externalLoad) nwr++;
        seen_done = m_done;
        if (rst) begin
            m_act  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_ld = 0; m_tk = 0; m_snt = 0;
                end
            end else if (lp) m_ld += int'(in_valid);
            else if (cp) m_tk++;
            else if (out_ready) begin
                m_snt++;
                if (m_snt == 1024) begin
                    m_act  = 0;
                    m_done = 1;
                end
            end
        end
        tcyc++;
        @(negedge clk);
    endtask

    task automatic run_frame(input int mode);
        int n = 0, stall = 0;
        first_ir = -1; done_at = -1; nwr = 0; seen_done = 0;
        while (!seen_done && n < 20000) begin
            if (mode == 0) begin
                start     = $urandom_range(0, 19) == 0;
                in_valid  = $urandom_range(0, 3) != 0;
                out_ready = $urandom_range(0, 3) != 0;
            end else if (mode == 1) begin
                start     = (n % 97) == 0;
                in_valid  = (n % 2) == 0;
                out_ready = !(m_act && m_ld == 1024 && m_tk == 5120 && m_snt == 37 && stall < 5);
                if (!out_ready) begin
                    stall++;
                    #1;
                    check("stall_bin", 32'(out_bin), 37);
                    check("stall_idx", 32'(externalIndexA), 'h290);
                end
            end else begin
                start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            end
            step();
            n++;
        end
        check("frame_end", 32'(seen_done), 1);
        if (mode == 1) begin
            check("stall_count", stall, 5);
            check("writes", nwr, 1024);
        end
        if (mode == 2) check("frame_len", done_at - first_ir, 7168);
    endtask

    initial begin
        int n = 0;
        repeat (3) step();
        rst = 1'b0;
        run_frame(0);
        run_frame(1);
        run_frame(2);
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        while (!(m_act && m_ld == 1024 && m_tk == 4 * 512 + 100) && n < 20000) begin
            step();
            n++;
        end
        check("pre_rst_stage", 32'(stageCount), 4);
        check("pre_rst_cycle", 32'(cycleCount), 100);
        #1 rst = 1'b1;
        #1;
        check("rst_now", {27'd0, load, busy, in_ready, scan, done}, 0);
        check("rst_counters", {stageCount, cycleCount, externalIndexA}, 0);
        m_act = 0;
        m_done = 0;
        step();
        step();
        rst = 1'b0;
        run_frame(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
